// File: rtl/fpu_wb_merge.sv
// FPU writeback merge: fixed pipes beat div/sqrt onto the single FP write port.
// Also accumulates fflags and throttles issue while a div/sqrt result starves.
module fpu_wb_merge #(
  parameter int NPIPES       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPIPES-1:0]     pipe_valid,
  input  logic [NPIPES*65-1:0]  pipe_data,
  input  logic [NPIPES*5-1:0]   pipe_exc,
  input  logic [NPIPES*5-1:0]   pipe_rd,
  input  logic                  div_valid,
  output logic                  div_ready,
  input  logic [64:0]           div_data,
  input  logic [4:0]            div_exc,
  input  logic [4:0]            div_rd,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [64:0]           wb_data,
  output logic [4:0]            wb_exc,
  input  logic                  fflags_we,
  input  logic [4:0]            fflags_wdata,
  output logic [4:0]            fflags,
  output logic                  issue_stall,
  output logic                  collision_err
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [64:0] data;
    logic [4:0]  exc;
  } wb_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STALL
  } state_t;

  localparam logic [NPIPES-1:0] ONE   = NPIPES'(1);
  localparam logic [3:0]        LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] cnt;
  logic       any_pipe;
  logic       div_fire;
  logic       blocked;
  logic       multi;
  logic       wb_next;
  wb_t        sel;

  assign any_pipe  = |pipe_valid;
  assign div_ready = ~any_pipe;
  assign div_fire  = div_valid & div_ready;
  assign blocked   = div_valid & ~div_ready;
  assign wb_next   = any_pipe | div_fire;

  // nonzero iff at least two bits of pipe_valid are set
  assign multi = |(pipe_valid & (pipe_valid - ONE));

  // walk downward so the lowest-index valid pipe is the last to assign
  always_comb begin
    sel = {div_rd, div_data, div_exc};
    for (int i = NPIPES - 1; i >= 0; i--) begin
      if (pipe_valid[i]) begin
        sel = {pipe_rd[5*i +: 5],
               pipe_data[65*i +: 65],
               pipe_exc[5*i +: 5]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exc        <= '0;
      fflags        <= '0;
      collision_err <= 1'b0;
    end else begin
      wb_valid      <= wb_next;
      collision_err <= collision_err | multi;
      if (wb_next) begin
        {wb_rd, wb_data, wb_exc} <= sel;
      end
      fflags <= (fflags_we ? fflags_wdata : fflags)
              | (wb_valid ? wb_exc : 5'd0);
    end
  end

  // issue_stall only rises while STALL is held, so it lags entry by a cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      issue_stall <= 1'b0;
    end else begin
      issue_stall <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (blocked) begin
            cnt   <= 4'd1;
            state <= (LIMIT == 4'd1) ? STALL : WAIT;
          end
        end
        WAIT: begin
          if (!blocked) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt + 4'd1 == LIMIT) begin
            state <= STALL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        STALL: begin
          if (!blocked) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            issue_stall <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_wb_merge.sv
// Directed bench for fpu_wb_merge with a writeback scoreboard.
// Expected writes are queued at drive time and popped when wb_valid pulses.
module tb_fpu_wb_merge;

  localparam int NP = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [64:0] data;
    logic [4:0]  exc;
  } wb_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     pipe_valid;
  logic [NP*65-1:0]  pipe_data;
  logic [NP*5-1:0]   pipe_exc;
  logic [NP*5-1:0]   pipe_rd;
  logic              div_valid;
  logic              div_ready;
  logic [64:0]       div_data;
  logic [4:0]        div_exc;
  logic [4:0]        div_rd;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [64:0]       wb_data;
  logic [4:0]        wb_exc;
  logic              fflags_we;
  logic [4:0]        fflags_wdata;
  logic [4:0]        fflags;
  logic              issue_stall;
  logic              collision_err;

  int  n_tests = 0;
  int  n_fail  = 0;
  wb_t q[$];

  fpu_wb_merge #(.NPIPES(NP), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .pipe_exc(pipe_exc), .pipe_rd(pipe_rd),
    .div_valid(div_valid), .div_ready(div_ready),
    .div_data(div_data), .div_exc(div_exc), .div_rd(div_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exc(wb_exc), .fflags_we(fflags_we),
    .fflags_wdata(fflags_wdata), .fflags(fflags),
    .issue_stall(issue_stall), .collision_err(collision_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write-port pulse must match the oldest expectation
  always @(negedge clock) begin
    if (wb_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("wb_unexpected", 128'(wb_rd), 128'h0);
        n_tests++;
        n_fail++;
        $error("FAIL wb_extra: observed write rd %0d expected none", wb_rd);
      end else begin
        wb_t e;
        e = q.pop_front();
        check("wb_result", 128'({wb_rd, wb_data, wb_exc}), 128'(e));
      end
    end
  end

  task automatic clr();
    pipe_valid   = '0;
    pipe_data    = '0;
    pipe_exc     = '0;
    pipe_rd      = '0;
    div_valid    = 1'b0;
    div_data     = '0;
    div_exc      = '0;
    div_rd       = '0;
    fflags_we    = 1'b0;
    fflags_wdata = '0;
  endtask

  task automatic set_pipe(input int i, input logic [64:0] d,
                          input logic [4:0] e, input logic [4:0] r);
    pipe_valid[i]       = 1'b1;
    pipe_data[65*i +: 65] = d;
    pipe_exc[5*i +: 5]    = e;
    pipe_rd[5*i +: 5]     = r;
  endtask

  task automatic set_div(input logic [64:0] d,
                         input logic [4:0] e, input logic [4:0] r);
    div_valid = 1'b1;
    div_data  = d;
    div_exc   = e;
    div_rd    = r;
  endtask

  task automatic push(input logic [4:0] r, input logic [64:0] d,
                      input logic [4:0] e);
    wb_t w;
    w.rd   = r;
    w.data = d;
    w.exc  = e;
    q.push_back(w);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_wb_valid"}, 128'(wb_valid), 128'h0);
    check({pfx, "_wb_rd"}, 128'(wb_rd), 128'h0);
    check({pfx, "_wb_data"}, 128'(wb_data), 128'h0);
    check({pfx, "_wb_exc"}, 128'(wb_exc), 128'h0);
    check({pfx, "_fflags"}, 128'(fflags), 128'h0);
    check({pfx, "_issue_stall"}, 128'(issue_stall), 128'h0);
    check({pfx, "_collision"}, 128'(collision_err), 128'h0);
  endtask

  task automatic starve(input int base);
    for (int k = 0; k < 6; k++) begin
      clr();
      set_div(65'h1_DEAD0000 + 65'(base), 5'h02, 5'd9);
      set_pipe(0, 65'h100 + 65'(base + k), 5'h08, 5'(k + 10));
      push(5'(k + 10), 65'h100 + 65'(base + k), 5'h08);
      #1;
      check("starve_div_ready", 128'(div_ready), 128'h0);
      cyc();
      check($sformatf("starve_stall_k%0d", k), 128'(issue_stall),
            128'(k >= 4));
    end
  endtask

  initial begin
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    check("reset_div_ready", 128'(div_ready), 128'h1);
    reset = 1'b0;

    // single pipe result and fflags at t+2
    set_pipe(1, 65'h0_3F800000, 5'h01, 5'd7);
    push(5'd7, 65'h0_3F800000, 5'h01);
    cyc();
    check("single_wb_valid", 128'(wb_valid), 128'h1);
    check("single_fflags_t1", 128'(fflags), 128'h0);
    clr();
    cyc();
    check("single_pulse", 128'(wb_valid), 128'h0);
    check("single_fflags_t2", 128'(fflags), 128'h01);

    // back-to-back writes from different pipes
    for (int k = 0; k < 3; k++) begin
      clr();
      set_pipe((k * 2) % 3, 65'h1_00000000 + 65'(k * 17), 5'(k), 5'(20 + k));
      push(5'(20 + k), 65'h1_00000000 + 65'(k * 17), 5'(k));
      cyc();
      check("b2b_wb_valid", 128'(wb_valid), 128'h1);
    end
    clr();
    cyc();

    // collision: lowest index wins, error is sticky
    check("coll_before", 128'(collision_err), 128'h0);
    set_pipe(0, 65'h0_AAAA, 5'h00, 5'd3);
    set_pipe(1, 65'h0_BBBB, 5'h08, 5'd5);
    push(5'd3, 65'h0_AAAA, 5'h00);
    cyc();
    check("coll_rd", 128'(wb_rd), 128'd3);
    check("coll_err", 128'(collision_err), 128'h1);
    clr();
    cyc();
    check("coll_one_write", 128'(wb_valid), 128'h0);
    check("coll_sticky", 128'(collision_err), 128'h1);

    // div/sqrt waits behind fixed pipes
    for (int k = 0; k < 2; k++) begin
      clr();
      set_div(65'h1_40000000, 5'h02, 5'd9);
      set_pipe(0, 65'h0_C000 + 65'(k), 5'h00, 5'(12 + k));
      push(5'(12 + k), 65'h0_C000 + 65'(k), 5'h00);
      #1;
      check("prio_div_ready_blk", 128'(div_ready), 128'h0);
      cyc();
      check("prio_no_stall", 128'(issue_stall), 128'h0);
    end
    clr();
    set_div(65'h1_40000000, 5'h02, 5'd9);
    #1;
    check("prio_div_ready_ok", 128'(div_ready), 128'h1);
    push(5'd9, 65'h1_40000000, 5'h02);
    cyc();
    check("prio_div_written", 128'(wb_rd), 128'd9);
    clr();
    cyc();
    check("prio_stall_after", 128'(issue_stall), 128'h0);

    // CSR write overlapping a retiring result
    fflags_we    = 1'b1;
    fflags_wdata = 5'h10;
    cyc();
    clr();
    check("csr_write", 128'(fflags), 128'h10);
    set_pipe(2, 65'h0_1234, 5'h04, 5'd1);
    push(5'd1, 65'h0_1234, 5'h04);
    cyc();
    check("csr_wb_exc", 128'(wb_exc), 128'h04);
    clr();
    fflags_we    = 1'b1;
    fflags_wdata = 5'h00;
    cyc();
    clr();
    check("csr_overlap", 128'(fflags), 128'h04);

    // starvation, then release
    starve(0);
    clr();
    set_div(65'h1_DEAD0000, 5'h02, 5'd9);
    #1;
    check("starve_release_ready", 128'(div_ready), 128'h1);
    push(5'd9, 65'h1_DEAD0000, 5'h02);
    cyc();
    check("starve_release_stall", 128'(issue_stall), 128'h0);
    clr();
    cyc();

    // reset while stalled
    starve(64);
    clr();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_zero("rst_stall");
    for (int k = 0; k < 4; k++) begin
      clr();
      set_div(65'h0_77, 5'h01, 5'd30);
      set_pipe(0, 65'h0_500 + 65'(k), 5'h00, 5'd4);
      push(5'd4, 65'h0_500 + 65'(k), 5'h00);
      cyc();
      check("rst_fsm_idle", 128'(issue_stall), 128'h0);
    end
    clr();
    set_div(65'h0_77, 5'h01, 5'd30);
    push(5'd30, 65'h0_77, 5'h01);
    cyc();
    clr();
    cyc();

    check("scoreboard_drained", 128'(q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
